// File: rtl/sensor_config_seq_pkg.sv
// Shared types for the sensor configuration sequencer: FSM encoding, error codes
// and the helper that recognises the all-ones marker fields in a ROM word.
package sensor_cfg_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StDecode,
        StWrite,
        StWaitW,
        StRead,
        StWaitR,
        StCheck,
        StDelay,
        StDone
    } state_e;

    localparam logic [1:0] ERR_NONE        = 2'd0;
    localparam logic [1:0] ERR_VERIFY_FAIL = 2'd1;
    localparam logic [1:0] ERR_NO_END      = 2'd2;

    // True when the low w bits of v are all ones.
    function automatic logic field_all_ones(input logic [31:0] v, input int w);
        logic [31:0] m;
        m = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (v & m) == m;
    endfunction

endpackage

// File: rtl/sensor_config_seq_if.sv
// Command-ROM and register-bus signals of the sensor configuration sequencer.
// master = sequencer side, slave = ROM/bus side.
interface sensor_config_seq_if #(
    parameter int ROM_AW = 8,
    parameter int REG_AW = 8,
    parameter int REG_DW = 8
);
    logic [ROM_AW-1:0]        rom_addr;
    logic [REG_AW+REG_DW-1:0] rom_data;
    logic                     bus_ready;
    logic                     bus_start;
    logic                     bus_rw;
    logic [REG_AW-1:0]        bus_addr;
    logic [REG_DW-1:0]        bus_wdata;
    logic [REG_DW-1:0]        bus_rdata;

    modport master (
        output rom_addr, bus_start, bus_rw, bus_addr, bus_wdata,
        input  rom_data, bus_ready, bus_rdata
    );

    modport slave (
        input  rom_addr, bus_start, bus_rw, bus_addr, bus_wdata,
        output rom_data, bus_ready, bus_rdata
    );
endinterface

// File: rtl/sensor_config_seq_delay_timer.sv
// Loadable down-counter for the millisecond delay entries; saturates at zero.
module cfg_delay_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    input  logic         i_count,
    output logic         o_zero
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (i_count && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/sensor_config_seq.sv
// Walks a command ROM of {reg addr, reg data} words, issuing register writes (with
// optional read-back verify and retry), millisecond delays, and stopping at END.
module sensor_config_seq
    import sensor_cfg_pkg::*;
#(
    parameter int CLK_FREQ  = 25000000,
    parameter int ROM_AW    = 8,
    parameter int REG_AW    = 8,
    parameter int REG_DW    = 8,
    parameter int VERIFY    = 0,
    parameter int MAX_RETRY = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    sensor_config_seq_if.master io_bus,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_error,
    output logic [ROM_AW-1:0]   o_err_index,
    output logic [1:0]          o_err_code
);
    localparam longint CYC_PER_MS = longint'(CLK_FREQ) / 1000;
    localparam longint MAX_CYC    = ((longint'(1) << REG_DW) - 1) * CYC_PER_MS;
    localparam int     TW         = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    state_e            r_state, w_state;
    logic [ROM_AW-1:0] r_rom_addr, w_rom_addr;
    logic              r_bus_rw, w_bus_rw;
    logic [REG_AW-1:0] r_bus_addr, w_bus_addr;
    logic [REG_DW-1:0] r_bus_wdata, w_bus_wdata;
    logic [REG_DW-1:0] r_rdata, w_rdata;
    logic              r_done, w_done;
    logic              r_error, w_error;
    logic [ROM_AW-1:0] r_err_index, w_err_index;
    logic [1:0]        r_err_code, w_err_code;
    logic [3:0]        r_retry, w_retry;
    logic              r_first, w_first;

    logic [REG_AW-1:0] w_fld_addr;
    logic [REG_DW-1:0] w_fld_data;
    logic              w_is_marker, w_is_end, w_advance, w_bus_start;
    logic              w_tmr_load, w_tmr_count, w_tmr_zero;
    logic [TW-1:0]     w_delay_load;

    assign {w_fld_addr, w_fld_data} = io_bus.rom_data;
    assign w_is_marker  = field_all_ones(32'(w_fld_addr), REG_AW);
    assign w_is_end     = w_is_marker && field_all_ones(32'(w_fld_data), REG_DW);
    assign w_delay_load = TW'(w_fld_data) * TW'(CYC_PER_MS) - TW'(1);

    cfg_delay_timer #(.W(TW)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_tmr_load),
        .i_value (w_delay_load),
        .i_count (w_tmr_count),
        .o_zero  (w_tmr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_rom_addr  <= '0;
            r_bus_rw    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_rdata     <= '0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_index <= '0;
            r_err_code  <= ERR_NONE;
            r_retry     <= '0;
            r_first     <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_rom_addr  <= w_rom_addr;
            r_bus_rw    <= w_bus_rw;
            r_bus_addr  <= w_bus_addr;
            r_bus_wdata <= w_bus_wdata;
            r_rdata     <= w_rdata;
            r_done      <= w_done;
            r_error     <= w_error;
            r_err_index <= w_err_index;
            r_err_code  <= w_err_code;
            r_retry     <= w_retry;
            r_first     <= w_first;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_rom_addr  = r_rom_addr;
        w_bus_rw    = r_bus_rw;
        w_bus_addr  = r_bus_addr;
        w_bus_wdata = r_bus_wdata;
        w_rdata     = r_rdata;
        w_done      = r_done;
        w_error     = r_error;
        w_err_index = r_err_index;
        w_err_code  = r_err_code;
        w_retry     = r_retry;
        w_first     = 1'b0;
        w_advance   = 1'b0;
        w_bus_start = 1'b0;
        w_tmr_load  = 1'b0;
        w_tmr_count = 1'b0;

        unique case (r_state)
            StIdle: begin
                w_rom_addr = '0;
                if (i_start) begin
                    w_state     = StFetch;
                    w_done      = 1'b0;
                    w_error     = 1'b0;
                    w_err_code  = ERR_NONE;
                    w_err_index = '0;
                    w_retry     = '0;
                end
            end
            StFetch: w_state = StDecode;
            StDecode: begin
                if (w_is_end) begin
                    w_done  = 1'b1;
                    w_state = StDone;
                end else if (w_is_marker) begin
                    if (w_fld_data == '0) begin
                        w_advance = 1'b1;
                    end else begin
                        w_tmr_load = 1'b1;
                        w_state    = StDelay;
                    end
                end else begin
                    w_bus_rw    = 1'b0;
                    w_bus_addr  = w_fld_addr;
                    w_bus_wdata = w_fld_data;
                    w_state     = StWrite;
                end
            end
            StWrite, StRead: begin
                if (io_bus.bus_ready) begin
                    w_bus_start = 1'b1;
                    w_first     = 1'b1;
                    w_state     = (r_state == StWrite) ? StWaitW : StWaitR;
                end
            end
            // r_first masks the ready left over from the cycle that issued bus_start.
            StWaitW: begin
                if (!r_first && io_bus.bus_ready) begin
                    if (VERIFY != 0) begin
                        w_bus_rw = 1'b1;
                        w_state  = StRead;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            StWaitR: begin
                if (!r_first && io_bus.bus_ready) begin
                    w_rdata = io_bus.bus_rdata;
                    w_state = StCheck;
                end
            end
            StCheck: begin
                if (r_rdata == r_bus_wdata) begin
                    w_advance = 1'b1;
                end else if (r_retry < 4'(MAX_RETRY)) begin
                    w_retry  = r_retry + 1'b1;
                    w_bus_rw = 1'b0;
                    w_state  = StWrite;
                end else begin
                    w_error     = 1'b1;
                    w_err_code  = ERR_VERIFY_FAIL;
                    w_err_index = r_rom_addr;
                    w_done      = 1'b1;
                    w_retry     = '0;
                    w_state     = StDone;
                end
            end
            StDelay: begin
                if (w_tmr_zero) w_advance = 1'b1;
                else            w_tmr_count = 1'b1;
            end
            StDone:  w_state = StIdle;
            default: w_state = StIdle;
        endcase

        // Entry finished: step to the next word, but never wrap past the last ROM slot.
        if (w_advance) begin
            w_retry = '0;
            if (&r_rom_addr) begin
                w_error     = 1'b1;
                w_err_code  = ERR_NO_END;
                w_err_index = r_rom_addr;
                w_done      = 1'b1;
                w_state     = StDone;
            end else begin
                w_rom_addr = r_rom_addr + 1'b1;
                w_state    = StFetch;
            end
        end
    end

    assign io_bus.rom_addr  = r_rom_addr;
    assign io_bus.bus_start = w_bus_start;
    assign io_bus.bus_rw    = r_bus_rw;
    assign io_bus.bus_addr  = r_bus_addr;
    assign io_bus.bus_wdata = r_bus_wdata;

    assign o_busy      = (r_state != StIdle);
    assign o_done      = r_done;
    assign o_error     = r_error;
    assign o_err_index = r_err_index;
    assign o_err_code  = r_err_code;
endmodule

// File: tb/tb_sensor_config_seq.sv
// Directed bench: instance A (ROM_AW=2, no verify) and instance B (verify, 3 retries),
// both at 1 MHz so one delay millisecond is 1000 cycles.
module tb_sensor_config_seq;
    import sensor_cfg_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start_a = 1'b0, busy_a, done_a, err_a;
    logic [1:0] idx_a, code_a;
    logic       start_b = 1'b0, busy_b, done_b, err_b;
    logic [7:0] idx_b;
    logic [1:0] code_b;

    sensor_config_seq_if #(.ROM_AW(2), .REG_AW(8), .REG_DW(8)) ifa ();
    sensor_config_seq_if #(.ROM_AW(8), .REG_AW(8), .REG_DW(8)) ifb ();

    sensor_config_seq #(
        .CLK_FREQ(1000000), .ROM_AW(2), .REG_AW(8), .REG_DW(8), .VERIFY(0), .MAX_RETRY(3)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .i_start(start_a), .io_bus(ifa), .o_busy(busy_a),
        .o_done(done_a), .o_error(err_a), .o_err_index(idx_a), .o_err_code(code_a)
    );

    sensor_config_seq #(
        .CLK_FREQ(1000000), .ROM_AW(8), .REG_AW(8), .REG_DW(8), .VERIFY(1), .MAX_RETRY(3)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .i_start(start_b), .io_bus(ifb), .o_busy(busy_b),
        .o_done(done_b), .o_error(err_b), .o_err_index(idx_b), .o_err_code(code_b)
    );

    // ROM models and bus responders
    logic [15:0] rom_a [4];
    logic [15:0] rom_b [256];
    always @(posedge clk) ifa.rom_data <= rom_a[ifa.rom_addr];
    always @(posedge clk) ifb.rom_data <= rom_b[ifb.rom_addr];

    int         wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0, rd_base = 0, ok_at = 1;
    logic [7:0] la_addr = 0, la_data = 0, lb_addr = 0, lb_data = 0, fail_addr = 8'hFF;

    always @(posedge clk) begin
        if (ifa.bus_start) begin
            if (ifa.bus_rw) rd_a++;
            else begin
                wr_a++;
                la_addr <= ifa.bus_addr;
                la_data <= ifa.bus_wdata;
            end
        end
    end

    // Read returns the written value only from read #ok_at of the run on, never for fail_addr.
    always @(posedge clk) begin
        if (ifb.bus_start) begin
            if (ifb.bus_rw) begin
                rd_b++;
                ifb.bus_rdata <= (ifb.bus_addr != fail_addr && (rd_b - rd_base) >= ok_at)
                                 ? ifb.bus_wdata : 8'h00;
            end else begin
                wr_b++;
                lb_addr <= ifb.bus_addr;
                lb_data <= ifb.bus_wdata;
            end
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, " busy"}, 32'(busy_a), 0);
        check({tag, " done"}, 32'(done_a), 0);
        check({tag, " error"}, 32'(err_a), 0);
        check({tag, " err_code"}, 32'(code_a), 0);
        check({tag, " err_index"}, 32'(idx_a), 0);
        check({tag, " rom_addr"}, 32'(ifa.rom_addr), 0);
        check({tag, " bus_start"}, 32'(ifa.bus_start), 0);
        check({tag, " bus_rw"}, 32'(ifa.bus_rw), 0);
        check({tag, " bus_addr"}, 32'(ifa.bus_addr), 0);
        check({tag, " bus_wdata"}, 32'(ifa.bus_wdata), 0);
    endtask

    task automatic pulse_start(input bit sel);
        @(negedge clk);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input bit sel, input string name, input int budget);
        int n = 0;
        while (!(sel ? done_b : done_a) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(sel ? done_b : done_a), 1);
    endtask

    typedef struct {
        bit              sel;
        logic [0:3][15:0] rom;
        int              ok_at;
        logic [7:0]      fail_addr;
        int              exp_wr;
        int              exp_rd;
        logic            exp_err;
        logic [1:0]      exp_code;
        logic [7:0]      exp_idx;
        logic [7:0]      exp_addr;
        logic [7:0]      exp_data;
    } vec_t;

    function automatic vec_t mk(input bit sel, input logic [0:3][15:0] rom, input int ok,
                                input logic [7:0] fa, input int wr, input int rd,
                                input logic err, input logic [1:0] code, input logic [7:0] idx,
                                input logic [7:0] addr, input logic [7:0] data);
        vec_t v;
        v.sel = sel; v.rom = rom; v.ok_at = ok; v.fail_addr = fa;
        v.exp_wr = wr; v.exp_rd = rd; v.exp_err = err; v.exp_code = code;
        v.exp_idx = idx; v.exp_addr = addr; v.exp_data = data;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int i);
        int    wr0, rd0;
        string t;
        t = $sformatf("v%0d", i);
        for (int k = 0; k < 256; k++) rom_b[k] = 16'hFFFF;
        for (int k = 0; k < 4; k++) begin
            if (v.sel) rom_b[k] = v.rom[k];
            else       rom_a[k] = v.rom[k];
        end
        ok_at     = v.ok_at;
        fail_addr = v.fail_addr;
        rd_base   = rd_b;
        wr0 = v.sel ? wr_b : wr_a;
        rd0 = v.sel ? rd_b : rd_a;
        pulse_start(v.sel);
        wait_done(v.sel, {t, " done"}, 3000);
        @(negedge clk);
        check({t, " busy after"}, 32'(v.sel ? busy_b : busy_a), 0);
        check({t, " done held"}, 32'(v.sel ? done_b : done_a), 1);
        check({t, " writes"}, 32'((v.sel ? wr_b : wr_a) - wr0), 32'(v.exp_wr));
        check({t, " reads"}, 32'((v.sel ? rd_b : rd_a) - rd0), 32'(v.exp_rd));
        check({t, " error"}, 32'(v.sel ? err_b : err_a), 32'(v.exp_err));
        check({t, " err_code"}, 32'(v.sel ? code_b : code_a), 32'(v.exp_code));
        check({t, " err_index"}, v.sel ? 32'(idx_b) : 32'(idx_a), 32'(v.exp_idx));
        if (v.exp_wr > 0) begin
            check({t, " last addr"}, 32'(v.sel ? lb_addr : la_addr), 32'(v.exp_addr));
            check({t, " last data"}, 32'(v.sel ? lb_data : la_data), 32'(v.exp_data));
        end
    endtask

    vec_t vecs[8];

    initial begin
        int wr0, cyc, lat;
        bit seen;

        vecs[0] = mk(0, {16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 1, 8'hFF, 1, 0, 0, 0, 0, 8'h12, 8'h80);
        vecs[1] = mk(0, {16'h1011, 16'h2022, 16'h3033, 16'h4044}, 1, 8'hFF, 4, 0, 1, 2, 3, 8'h40, 8'h44);
        vecs[2] = mk(0, {16'hFF00, 16'h5566, 16'hFFFF, 16'hFFFF}, 1, 8'hFF, 1, 0, 0, 0, 0, 8'h55, 8'h66);
        vecs[3] = mk(0, {16'hFF01, 16'h7788, 16'hFFFF, 16'hFFFF}, 1, 8'hFF, 1, 0, 0, 0, 0, 8'h77, 8'h88);
        vecs[4] = mk(1, {16'h3A80, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 3, 8'hFF, 3, 3, 0, 0, 0, 8'h3A, 8'h80);
        vecs[5] = mk(1, {16'h1111, 16'h2222, 16'hFFFF, 16'hFFFF}, 1, 8'h22, 5, 5, 1, 1, 1, 8'h22, 8'h22);
        vecs[6] = mk(1, {16'h0102, 16'hFF01, 16'h0304, 16'hFFFF}, 1, 8'hFF, 2, 2, 0, 0, 0, 8'h03, 8'h04);
        vecs[7] = mk(0, {16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00}, 1, 8'hFF, 0, 0, 1, 2, 3, 8'h00, 8'h00);

        ifa.bus_ready = 1'b1;
        ifa.bus_rdata = 8'h00;
        ifb.bus_ready = 1'b1;

        #3;
        check_reset_a("por");
        check("por b busy", 32'(busy_b), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Delay-only program: 2 ms at 1 MHz, no bus activity
        rom_a[0] = 16'hFF02; rom_a[1] = 16'hFFFF; rom_a[2] = 16'hFFFF; rom_a[3] = 16'hFFFF;
        wr0 = wr_a + rd_a;
        pulse_start(0);
        cyc = 1;
        while (!done_a && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        lat = cyc - 1;
        check("delay done", 32'(done_a), 1);
        check("delay latency in 2000..2004", 32'(lat >= 2000 && lat <= 2004), 1);
        check("delay no bus_start", 32'(wr_a + rd_a - wr0), 0);

        // Reset while waiting for write completion
        rom_a[0] = 16'h1280; rom_a[1] = 16'hFFFF;
        pulse_start(0);
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (ifa.bus_start) seen = 1;
            else @(negedge clk);
        end
        check("wait_w bus_start seen", 32'(seen), 1);
        @(posedge clk);
        #1 ifa.bus_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("wait_w busy before reset", 32'(busy_a), 1);
        #2 rst_n = 1'b0;
        #1 check_reset_a("rst wait_w");
        ifa.bus_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        wr0 = wr_a + rd_a;
        repeat (5) @(negedge clk);
        check("post-reset no bus_start", 32'(wr_a + rd_a - wr0), 0);
        check("post-reset idle", 32'(busy_a), 0);

        // Restart with bus held not-ready: write must wait for it
        ifa.bus_ready = 1'b0;
        wr0 = wr_a;
        pulse_start(0);
        check("restart rom_addr", 32'(ifa.rom_addr), 0);
        repeat (10) @(negedge clk);
        check("no start while not ready", 32'(wr_a - wr0), 0);
        check("busy while not ready", 32'(busy_a), 1);
        ifa.bus_ready = 1'b1;
        wait_done(0, "restart done", 100);
        check("restart writes", 32'(wr_a - wr0), 1);
        check("restart error", 32'(err_a), 0);

        // Reset in the middle of a delay
        rom_a[0] = 16'hFF05;
        pulse_start(0);
        repeat (50) @(negedge clk);
        check("delay busy before reset", 32'(busy_a), 1);
        #2 rst_n = 1'b0;
        #1 check_reset_a("rst delay");
        @(negedge clk);
        rst_n = 1'b1;
        rom_a[0] = 16'h1280;
        wr0 = wr_a;
        pulse_start(0);
        check("delay restart rom_addr", 32'(ifa.rom_addr), 0);
        wait_done(0, "delay restart done", 100);
        check("delay restart writes", 32'(wr_a - wr0), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
